// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
//
// Sits beside execute and produces three kinds of control:
//   * Operand forwarding selects for decode->execute (combinational).
//   * A load-use stall for fetch/decode (combinational).
//   * A PC redirect to fetch on a taken branch/jump in execute, with a flush of the
//     wrong-path instructions in the IF/ID and ID/EX registers.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   id_rs1/id_rs2         decode-stage source register addresses
//   id_use_rs1/id_use_rs2 decode instruction actually reads that source
//   ex_valid/ex_rd        execute-stage valid and destination
//   ex_load               execute instruction is a load (result not ready yet)
//   ex_fire               execute handshake
//   branch/target         execute: branch/jump taken and its target
//   mm_valid/mm_rd        memory-stage valid and destination
//   wb_valid/wb_rd        writeback-stage valid and destination
//   fwd_rs1/fwd_rs2       operand source: 0 regfile, 1 EX, 2 MM, 3 WB
//   stall                 hold PC and IF/ID, insert a bubble into EX
//   flush                 invalidate IF/ID and ID/EX
//   redirect_valid/pc     new PC offered to fetch
//   redirect_ready        fetch accepted the redirect
//
// FLUSH_CYCLES must be at least 1.
module hazard_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load,
  input  logic              ex_fire,
  input  logic              branch,
  input  logic [XLEN-1:0]   target,
  input  logic              mm_valid,
  input  logic [REG_AW-1:0] mm_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_rs1,
  output logic [1:0]        fwd_rs2,
  output logic              stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready
);

  localparam int unsigned     CntW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // The take cycle itself is the first flush cycle, so FLUSH runs FLUSH_CYCLES cycles
  // starting from FLUSH_CYCLES-1 down to 0.
  localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES - 1);

  localparam logic [1:0] SelRf = 2'd0;
  localparam logic [1:0] SelEx = 2'd1;
  localparam logic [1:0] SelMm = 2'd2;
  localparam logic [1:0] SelWb = 2'd3;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rv_q, rv_d;
  logic [XLEN-1:0]   pc_q, pc_d;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  // x0 is hardwired zero, so a write to it must never be bypassed.
  function automatic logic hit(input logic            use_src,
                               input logic [REG_AW-1:0] addr,
                               input logic            stage_valid,
                               input logic [REG_AW-1:0] stage_rd);
    hit = use_src & (addr != '0) & stage_valid & (stage_rd == addr);
  endfunction

  logic ex_hit_rs1, mm_hit_rs1, wb_hit_rs1;
  logic ex_hit_rs2, mm_hit_rs2, wb_hit_rs2;
  logic load_use;

  always_comb begin
    ex_hit_rs1 = hit(id_use_rs1, id_rs1, ex_valid, ex_rd);
    mm_hit_rs1 = hit(id_use_rs1, id_rs1, mm_valid, mm_rd);
    wb_hit_rs1 = hit(id_use_rs1, id_rs1, wb_valid, wb_rd);
    ex_hit_rs2 = hit(id_use_rs2, id_rs2, ex_valid, ex_rd);
    mm_hit_rs2 = hit(id_use_rs2, id_rs2, mm_valid, mm_rd);
    wb_hit_rs2 = hit(id_use_rs2, id_rs2, wb_valid, wb_rd);

    // A load in EX has no data yet: its match is skipped here and the stall covers it.
    if (ex_hit_rs1 && !ex_load) begin
      fwd_rs1 = SelEx;
    end else if (mm_hit_rs1) begin
      fwd_rs1 = SelMm;
    end else if (wb_hit_rs1) begin
      fwd_rs1 = SelWb;
    end else begin
      fwd_rs1 = SelRf;
    end

    if (ex_hit_rs2 && !ex_load) begin
      fwd_rs2 = SelEx;
    end else if (mm_hit_rs2) begin
      fwd_rs2 = SelMm;
    end else if (wb_hit_rs2) begin
      fwd_rs2 = SelWb;
    end else begin
      fwd_rs2 = SelRf;
    end

    load_use = ex_load & (ex_hit_rs1 | ex_hit_rs2);
  end

  // ---------------------------------------------------------------------------
  // Redirect / flush FSM
  // ---------------------------------------------------------------------------
  logic take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    pc_d    = pc_q;
    take    = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;

    case (state_q)
      StRun: begin
        take  = ex_fire & branch;
        // A taken branch squashes the instruction that caused the load-use hazard.
        stall = load_use & ~take;
        flush = take;
        if (take) begin
          pc_d    = target;
          rv_d    = 1'b1;
          cnt_d   = CntInit;
          state_d = StFlush;
        end
      end
      StFlush: begin
        // Everything arriving here is wrong-path: branch/ex_fire are ignored.
        flush = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end
        if (rv_q && redirect_ready) begin
          rv_d = 1'b0;
        end
        // rv_q low inside FLUSH means the redirect was accepted on an earlier cycle.
        if ((cnt_q == '0) && (!rv_q || redirect_ready)) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (areset) begin
      stall = 1'b0;
      flush = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      pc_q    <= pc_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_rv_hold: assert property (@(posedge aclk) disable iff (areset)
    (rv_q && !redirect_ready) |=> rv_q);

  a_pc_stable: assert property (@(posedge aclk) disable iff (areset)
    (rv_q && !redirect_ready) |=> $stable(pc_q));

  a_no_stall_in_flush: assert property (@(posedge aclk) disable iff (areset)
    !(stall && flush));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. The stimulus process drives one vector per cycle
// and pushes the hand-computed expected outputs; a monitor pops and compares on the
// falling edge.
module tb_hazard_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              aclk;
  logic              areset;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd, mm_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2;
  logic              ex_valid, ex_load, ex_fire, branch;
  logic [XLEN-1:0]   target;
  logic              mm_valid, wb_valid;
  logic [1:0]        fwd_rs1, fwd_rs2;
  logic              stall, flush, redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              redirect_ready;

  hazard_ctrl #(
    .XLEN        (XLEN),
    .REG_AW      (REG_AW),
    .FLUSH_CYCLES(2)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_load       (ex_load),
    .ex_fire       (ex_fire),
    .branch        (branch),
    .target        (target),
    .mm_valid      (mm_valid),
    .mm_rd         (mm_rd),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .fwd_rs1       (fwd_rs1),
    .fwd_rs2       (fwd_rs2),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ready(redirect_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [1:0]      f1;
    logic [1:0]      f2;
    logic            st;
    logic            fl;
    logic            rv;
    logic [XLEN-1:0] pc;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic clr();
    areset         = 1'b0;
    id_rs1         = '0;
    id_rs2         = '0;
    id_use_rs1     = 1'b0;
    id_use_rs2     = 1'b0;
    ex_valid       = 1'b0;
    ex_rd          = '0;
    ex_load        = 1'b0;
    ex_fire        = 1'b0;
    branch         = 1'b0;
    target         = '0;
    mm_valid       = 1'b0;
    mm_rd          = '0;
    wb_valid       = 1'b0;
    wb_rd          = '0;
    redirect_ready = 1'b0;
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
    clr();
  endtask

  task automatic expect_out(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                            input logic st, input logic fl, input logic rv,
                            input logic [XLEN-1:0] pc);
    obs_t e;
    e.f1 = f1;
    e.f2 = f2;
    e.st = st;
    e.fl = fl;
    e.rv = rv;
    e.pc = pc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor
  always @(negedge aclk) begin
    if (exp_q.size() != 0) begin
      obs_t  e;
      obs_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{f1: fwd_rs1, f2: fwd_rs2, st: stall, fl: flush, rv: redirect_valid,
             pc: redirect_pc};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got fwd1=%0d fwd2=%0d stall=%b flush=%b rv=%b pc=%h, want fwd1=%0d fwd2=%0d stall=%b flush=%b rv=%b pc=%h",
                 nm, a.f1, a.f2, a.st, a.fl, a.rv, a.pc, e.f1, e.f2, e.st, e.fl, e.rv, e.pc);
      end
    end
  end

  initial begin
    clr();
    areset = 1'b1;
    repeat (3) @(posedge aclk);

    // Reset state and forwarding.
    nxt(); expect_out("reset_state", 0, 0, 0, 0, 0, 32'h0);
    nxt(); id_rs1 = 5; id_use_rs1 = 1; ex_valid = 1; ex_rd = 5; mm_valid = 1; mm_rd = 5;
           expect_out("ex_priority", 1, 0, 0, 0, 0, 32'h0);
    nxt(); id_rs1 = 3; id_use_rs1 = 1; id_rs2 = 9; id_use_rs2 = 1;
           mm_valid = 1; mm_rd = 9; wb_valid = 1; wb_rd = 3;
           expect_out("mm_wb_select", 3, 2, 0, 0, 0, 32'h0);
    nxt(); id_use_rs1 = 1; id_use_rs2 = 1; ex_valid = 1; ex_load = 1;
           mm_valid = 1; wb_valid = 1;
           expect_out("x0_never_fwd", 0, 0, 0, 0, 0, 32'h0);
    nxt(); id_rs1 = 5; ex_valid = 1; ex_rd = 5;
           expect_out("use_off", 0, 0, 0, 0, 0, 32'h0);

    // Load-use.
    nxt(); id_rs1 = 7; id_use_rs1 = 1; ex_valid = 1; ex_rd = 7; ex_load = 1;
           expect_out("load_use_stall", 0, 0, 1, 0, 0, 32'h0);
    nxt(); id_rs1 = 7; id_use_rs1 = 1; mm_valid = 1; mm_rd = 7;
           expect_out("load_then_mm", 2, 0, 0, 0, 0, 32'h0);
    nxt(); id_rs2 = 4; id_use_rs2 = 1; ex_valid = 1; ex_rd = 4; ex_load = 1;
           wb_valid = 1; wb_rd = 4;
           expect_out("load_use_rs2", 0, 3, 1, 0, 0, 32'h0);

    // Taken branch, redirect accepted at once.
    nxt(); ex_fire = 1; branch = 1; target = 32'h0000_0100; redirect_ready = 1;
           expect_out("take", 0, 0, 0, 1, 0, 32'h0);
    nxt(); redirect_ready = 1; ex_fire = 1; branch = 1; target = 32'h0000_0200;
           id_rs1 = 7; id_use_rs1 = 1; ex_valid = 1; ex_rd = 7; ex_load = 1;
           expect_out("flush_cyc1", 0, 0, 0, 1, 1, 32'h0000_0100);
    nxt(); redirect_ready = 1;
           expect_out("flush_cyc2", 0, 0, 0, 1, 0, 32'h0000_0100);
    nxt(); expect_out("back_in_run", 0, 0, 0, 0, 0, 32'h0000_0100);

    // Taken branch, fetch holds off for five cycles.
    nxt(); ex_fire = 1; branch = 1; target = 32'hdead_beef;
           expect_out("take_slow", 0, 0, 0, 1, 0, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      nxt(); expect_out($sformatf("hold_%0d", i), 0, 0, 0, 1, 1, 32'hdead_beef);
    end
    nxt(); redirect_ready = 1;
           expect_out("accept", 0, 0, 0, 1, 1, 32'hdead_beef);
    nxt(); expect_out("after_accept", 0, 0, 0, 0, 0, 32'hdead_beef);

    // Branch coincident with load-use, then reset mid-FLUSH.
    nxt(); id_rs1 = 7; id_use_rs1 = 1; ex_valid = 1; ex_rd = 7; ex_load = 1;
           ex_fire = 1; branch = 1; target = 32'h0000_0040;
           expect_out("take_vs_loaduse", 0, 0, 0, 1, 0, 32'hdead_beef);
    nxt(); expect_out("flush_before_rst", 0, 0, 0, 1, 1, 32'h0000_0040);
    nxt(); areset = 1'b1;
    nxt(); expect_out("post_reset", 0, 0, 0, 0, 0, 32'h0);
    nxt(); id_rs1 = 12; id_use_rs1 = 1; id_rs2 = 12; id_use_rs2 = 1;
           mm_rd = 12; wb_valid = 1; wb_rd = 12;
           expect_out("wb_only", 3, 3, 0, 0, 0, 32'h0);
    nxt();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge aclk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
